unidad_de_codificacion: RTL

UNIDAD_DE_CODIFICACION -- requirements
Module: unidad_de_codificacion

---
 rtl/unidad_de_codificacion.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/unidad_de_codificacion.sv
// Immediate encoder: finds the shortest extension format whose re-extension reproduces a 32-bit value.
// One candidate per TRY cycle; start is ignored while busy, results held until the next operation ends.
module unidad_de_codificacion (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] dataI,
  input  logic        ForceFmt,
  input  logic [1:0]  ExtImmReq,
  output logic        busy,
  output logic        done,
  output logic        fits,
  output logic [1:0]  ExtImm,
  output logic [23:0] dataO
);

  typedef enum logic [1:0] {IDLE, TRY, DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] val_q, val_d;
  logic        force_q, force_d;
  logic [1:0]  req_q, req_d;
  logic [1:0]  idx_q, idx_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        fits_q, fits_d;
  logic [1:0]  ext_imm_q, ext_imm_d;
  logic [23:0] data_o_q, data_o_d;

  logic [1:0]  auto_fmt;
  logic [1:0]  fmt;
  logic [23:0] field;
  logic [31:0] reext;
  logic        fit;

  // Search order runs from cheapest encoding to the widest one.
  always_comb begin
    case (idx_q)
      2'd0:    auto_fmt = 2'b11;
      2'd1:    auto_fmt = 2'b00;
      2'd2:    auto_fmt = 2'b10;
      default: auto_fmt = 2'b01;
    endcase
    fmt = force_q ? req_q : auto_fmt;
  end

  always_comb begin
    case (fmt)
      2'b00: begin
        field = {16'b0, val_q[7:0]};
        reext = {{24{val_q[7]}}, val_q[7:0]};
      end
      2'b01: begin
        field = val_q[23:0];
        reext = {{8{val_q[23]}}, val_q[23:0]};
      end
      2'b10: begin
        field = {12'b0, val_q[11:0]};
        reext = {{20{val_q[11]}}, val_q[11:0]};
      end
      default: begin
        field = 24'h000000;
        reext = 32'h00000000;
      end
    endcase
    fit = (reext == val_q);
  end

  always_comb begin
    state_d   = state_q;
    val_d     = val_q;
    force_d   = force_q;
    req_d     = req_q;
    idx_d     = idx_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    fits_d    = fits_q;
    ext_imm_d = ext_imm_q;
    data_o_d  = data_o_q;
    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          val_d   = dataI;
          force_d = ForceFmt;
          req_d   = ExtImmReq;
          idx_d   = 2'd0;
          busy_d  = 1'b1;
          state_d = TRY;
        end
      end
      TRY: begin
        // The last automatic candidate is format 01, so exhaustion already yields ExtImm=01, dataO=V[23:0].
        if (fit || force_q || (idx_q == 2'd3)) begin
          data_o_d  = field;
          ext_imm_d = fmt;
          fits_d    = fit;
          done_d    = 1'b1;
          state_d   = DONE;
        end else begin
          idx_d = idx_q + 2'd1;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      val_q     <= 32'h00000000;
      force_q   <= 1'b0;
      req_q     <= 2'b00;
      idx_q     <= 2'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      fits_q    <= 1'b0;
      ext_imm_q <= 2'b11;
      data_o_q  <= 24'h000000;
    end else begin
      state_q   <= state_d;
      val_q     <= val_d;
      force_q   <= force_d;
      req_q     <= req_d;
      idx_q     <= idx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      fits_q    <= fits_d;
      ext_imm_q <= ext_imm_d;
      data_o_q  <= data_o_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign fits   = fits_q;
  assign ExtImm = ext_imm_q;
  assign dataO  = data_o_q;

endmodule
